// File: rtl/signed_div_32bit_seq_pkg.sv
// Shared definitions for the sequential 32-bit RV32M divider.
// Holds the datapath width, the op encoding (RV32M funct3[1:0]),
// the controller state encoding and the fixed operation latency.
package signed_div_32bit_seq_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned DIV_LATENCY = 33;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Signed ops have op[0] == 0; remainder ops have op[1] == 1.
    function automatic logic op_is_signed(input logic [1:0] o);
        return ~o[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] o);
        return o[1];
    endfunction

endpackage

// File: rtl/signed_div_32bit_seq_cond_neg.sv
// Conditional two's-complement negation: dout = ctl ? -din : din.
// Ports:
//   ctl  - negate when high
//   din  - 32-bit input value
//   dout - 32-bit output value
module cond_neg_32bit
    import signed_div_32bit_seq_pkg::*;
(
    input  logic            ctl,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout
);

    always_comb begin
        dout = ctl ? (~din + {{(XLEN-1){1'b0}}, 1'b1}) : din;
    end

endmodule

// File: rtl/signed_div_32bit_seq.sv
// Sequential restoring divider for RV32M DIV/DIVU/REM/REMU.
// One shift-subtract step per cycle, fixed 33-cycle latency from the
// accepting edge to the done pulse for every operand value.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only in IDLE
//   abort  - synchronous kill of an in-flight operation
//   op     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b   - dividend / divisor, sampled with start
//   busy   - high while an operation is in flight
//   done   - one-cycle pulse, result valid while high
//   result - quotient or remainder, held until the next done
module signed_div_32bit_seq
    import signed_div_32bit_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e          state;
    op_e             op_q;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quo;      // dividend shifts out MSB-first, quotient bits shift in
    logic [XLEN:0]   rem;      // 33-bit partial remainder
    logic [5:0]      cnt;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;

    logic            neg_a_ctl;
    logic            neg_b_ctl;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic            fits;

    logic            fix_ctl;
    logic [XLEN-1:0] res_sel;
    logic [XLEN-1:0] res_fixed;

    // Operand magnitudes; unsigned ops pass the raw value through.
    always_comb begin
        neg_a_ctl = op_is_signed(op) & a[XLEN-1];
        neg_b_ctl = op_is_signed(op) & b[XLEN-1];
    end

    cond_neg_32bit u_neg_a (.ctl(neg_a_ctl), .din(a), .dout(abs_a));
    cond_neg_32bit u_neg_b (.ctl(neg_b_ctl), .din(b), .dout(abs_b));

    // Restoring step: the 34-bit difference's top bit is the borrow.
    always_comb begin
        rem_shift = {rem[XLEN-1:0], quo[XLEN-1]};
        diff      = {rem, quo[XLEN-1]} - {2'b00, divisor};
        fits      = ~diff[XLEN+1];
    end

    // A zero divisor yields quotient all-ones and remainder |a| from the
    // plain datapath; only the quotient sign fix-up must be suppressed so
    // DIV by zero stays 0xFFFFFFFF while REM by zero restores a's sign.
    always_comb begin
        if (op_is_rem(op_q)) begin
            res_sel = rem[XLEN-1:0];
            fix_ctl = op_is_signed(op_q) & sign_a;
        end else begin
            res_sel = quo;
            fix_ctl = op_is_signed(op_q) & (sign_a ^ sign_b) & ~div_zero;
        end
    end

    cond_neg_32bit u_neg_res (.ctl(fix_ctl), .din(res_sel), .dout(res_fixed));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_DIV;
            divisor  <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op_e'(op);
                        quo      <= abs_a;
                        divisor  <= abs_b;
                        sign_a   <= neg_a_ctl;
                        sign_b   <= neg_b_ctl;
                        div_zero <= (b == '0);
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        rem   <= fits ? diff[XLEN:0] : rem_shift;
                        quo   <= {quo[XLEN-2:0], fits};
                        cnt   <= cnt + 6'd1;
                        if (cnt == 6'(XLEN - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!abort) begin
                        result <= res_fixed;
                        done   <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_div_32bit_seq.sv
// Self-checking bench for signed_div_32bit_seq: directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written handshake / abort / reset sequences.
module tb_signed_div_32bit_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    signed_div_32bit_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // RV32M division semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                if (y == 0) return 32'hFFFF_FFFF;
                r = sx / sy;
                return r[31:0];
            end
            2'b01: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'b10: begin
                if (y == 0) return x;
                r = sx % sy;
                return r[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Called at a negedge: drives start, waits for done with a bound,
    // checks latency, busy throughout, result and single-cycle done.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        int cyc;
        bit busy_ok;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after acceptance; the operation must not notice.
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'd33);
        check({name, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({name, " result"}, result, exp);
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
        check({name, " result_hold"}, result, exp);
    endtask

    logic [31:0] last_res;

    initial begin
        vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001};
        vecs[3]  = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[5]  = '{2'b00, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[10] = '{2'b00, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2};
        vecs[11] = '{2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = $urandom_range(1, 15);
                2: rb = -($urandom_range(1, 15));
                default: rb = $urandom >> $urandom_range(0, 28);
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb, ref_result(ro, ra, rb));
        end

        // Handshake: ignored re-start, abort, immediate restart.
        last_res = result;
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) begin
                start = 1'b1; op = 2'b11; a = 32'd77; b = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (c == 10) abort = 1'b1;
            @(negedge clk);
            if (c == 6) check("hs busy_after_restart", {31'd0, busy}, 32'd1);
        end
        abort = 1'b0;
        check("hs abort busy", {31'd0, busy}, 32'd0);
        check("hs abort done", {31'd0, done}, 32'd0);
        check("hs abort result", result, last_res);
        run_op("hs restart", 2'b00, 32'hFFFF_FC18, 32'd7, ref_result(2'b00, 32'hFFFF_FC18, 32'd7));

        // Reset mid-operation.
        start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd10;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst divu", 2'b01, 32'd100, 32'd7, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
